// File: rtl/perm_rd_agu.sv
// Read-side address generator for the 4-bank conflict-free radix-4 FFT memory.
// Optional HOLD_CNT output is enabled by defining PERM_RD_AGU_HOLD_CNT_EN.
module perm_rd_agu #(
    parameter int N_LOG2 = 10,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = N_LOG2 - 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    input  logic [3:0]        STAGE,
    input  logic              HOLD,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] RD_ADDR0,
    output logic [ADDR_W-1:0] RD_ADDR1,
    output logic [ADDR_W-1:0] RD_ADDR2,
    output logic [ADDR_W-1:0] RD_ADDR3,
    output logic [1:0]        SEL_OUT,
    output logic              VALID_OUT,
    output logic              BUSY,
    output logic              DONE
`ifdef PERM_RD_AGU_HOLD_CNT_EN
    ,
    output logic [15:0]       HOLD_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [3:0]        NUM_STG = 4'(N_LOG2 / 2);
    localparam logic [ADDR_W-1:0] K_LAST  = '1;
    localparam logic [ADDR_W-1:0] K_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [N_LOG2-1:0] P_ONE   = {{(N_LOG2-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [3:0]        stage_q, stage_d;
    logic [3:0]        dl_q [RD_LAT];
    logic [3:0]        dl_in;

    logic              issue, accept, last;
    logic [5:0]        sh;
    logic [N_LOG2-1:0] kx, mask, base, pt;
    logic [1:0]        b0;
    logic [ADDR_W-1:0] addr_c [4];

    function automatic logic [1:0] digit_sum(input logic [N_LOG2-1:0] v);
        logic [1:0] acc;
        acc = 2'b00;
        for (int d = 0; d < N_LOG2 / 2; d++) acc = acc + v[2*d +: 2];
        return acc;
    endfunction

    // Group k at stage s: four points spaced 4^s apart, rotated onto banks from b0
    always_comb begin
        sh   = {1'b0, stage_q, 1'b0};
        kx   = {2'b00, k_q};
        mask = (P_ONE << sh) - P_ONE;
        base = ((kx >> sh) << (sh + 6'd2)) | (kx & mask);
        b0   = digit_sum(base);
        pt   = '0;
        for (int b = 0; b < 4; b++) addr_c[b] = '0;
        for (int j = 0; j < 4; j++) begin
            pt = base + ({{(N_LOG2-2){1'b0}}, 2'(j)} << sh);
            addr_c[b0 + 2'(j)] = ADDR_W'(pt >> 2);
        end
    end

    assign issue  = (state_q == RUN) && !HOLD;
    assign accept = (state_q == IDLE) && START && (STAGE < NUM_STG);
    assign last   = (k_q == K_LAST);
    assign dl_in  = issue ? {1'b1, last, b0} : 4'b0000;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    k_d     = '0;
                    stage_d = STAGE;
                end
            end
            RUN: begin
                if (issue) begin
                    k_d = k_q + K_ONE;
                    if (last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (DONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Delay line {valid, last, sel} matches the bank read latency
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            dl_q[0] <= dl_in;
            for (int i = 1; i < RD_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign RD_EN     = issue;
    assign RD_ADDR0  = issue ? addr_c[0] : '0;
    assign RD_ADDR1  = issue ? addr_c[1] : '0;
    assign RD_ADDR2  = issue ? addr_c[2] : '0;
    assign RD_ADDR3  = issue ? addr_c[3] : '0;
    assign VALID_OUT = dl_q[RD_LAT-1][3];
    assign DONE      = dl_q[RD_LAT-1][3] & dl_q[RD_LAT-1][2];
    assign SEL_OUT   = dl_q[RD_LAT-1][1:0];
    assign BUSY      = (state_q != IDLE);

`ifdef PERM_RD_AGU_HOLD_CNT_EN
    logic [15:0] hold_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hold_cnt_q <= '0;
        end else if (accept) begin
            hold_cnt_q <= '0;
        end else if ((state_q == RUN) && HOLD && (hold_cnt_q != 16'hFFFF)) begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
        end
    end

    assign HOLD_CNT = hold_cnt_q;
`endif

endmodule

// File: tb/tb_perm_rd_agu.sv
// Bench for perm_rd_agu: a 16-point/RD_LAT=1 and a 64-point/RD_LAT=3 instance share stimulus.
module tb_perm_rd_agu;
    logic       CLK = 1'b0;
    logic       RSTn, START, HOLD;
    logic [3:0] STAGE;

    logic       a_rd_en, a_vld, a_busy, a_done;
    logic [1:0] a_addr0, a_addr1, a_addr2, a_addr3, a_sel;
    logic       b_rd_en, b_vld, b_busy, b_done;
    logic [3:0] b_addr0, b_addr1, b_addr2, b_addr3;
    logic [1:0] b_sel;
`ifdef PERM_RD_AGU_HOLD_CNT_EN
    logic [15:0] a_hc, b_hc;
`endif

    int checks = 0, failures = 0, cyc = 0;

    always #5 CLK = ~CLK;

    perm_rd_agu #(.N_LOG2(4), .RD_LAT(1)) u_a (
        .CLK(CLK), .RSTn(RSTn), .START(START), .STAGE(STAGE), .HOLD(HOLD),
        .RD_EN(a_rd_en), .RD_ADDR0(a_addr0), .RD_ADDR1(a_addr1), .RD_ADDR2(a_addr2),
        .RD_ADDR3(a_addr3), .SEL_OUT(a_sel), .VALID_OUT(a_vld), .BUSY(a_busy), .DONE(a_done)
`ifdef PERM_RD_AGU_HOLD_CNT_EN
        , .HOLD_CNT(a_hc)
`endif
    );

    perm_rd_agu #(.N_LOG2(6), .RD_LAT(3)) u_b (
        .CLK(CLK), .RSTn(RSTn), .START(START), .STAGE(STAGE), .HOLD(HOLD),
        .RD_EN(b_rd_en), .RD_ADDR0(b_addr0), .RD_ADDR1(b_addr1), .RD_ADDR2(b_addr2),
        .RD_ADDR3(b_addr3), .SEL_OUT(b_sel), .VALID_OUT(b_vld), .BUSY(b_busy), .DONE(b_done)
`ifdef PERM_RD_AGU_HOLD_CNT_EN
        , .HOLD_CNT(b_hc)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model: point arithmetic and a schedule ring
    function automatic int lat_of(input int id);  return (id == 0) ? 1 : 3; endfunction
    function automatic int nlog_of(input int id); return (id == 0) ? 4 : 6; endfunction

    function automatic int dsum(input int v);
        int s, x;
        s = 0; x = v;
        while (x > 0) begin s += x % 4; x = x / 4; end
        return s % 4;
    endfunction

    function automatic int gbase(input int s, input int k);
        int q;
        q = 1 << (2 * s);
        return (k / q) * q * 4 + (k % q);
    endfunction

    function automatic int gpt(input int s, input int k, input int j);
        return gbase(s, k) + j * (1 << (2 * s));
    endfunction

    function automatic int gaddr(input int s, input int k, input int bank);
        int j;
        j = (bank - dsum(gbase(s, k)) + 4) % 4;
        return gpt(s, k, j) / 4;
    endfunction

    // value stored at (bank, addr) when every point i sits at bank b(i), address i/4
    function automatic int inv(input int b, input int a);
        for (int i = 4 * a; i < 4 * a + 4; i++) if (dsum(i) == b) return i;
        return -1;
    endfunction

    int m_iss[2], m_drain[2], m_k[2], m_s[2], m_hc[2];
    int rv[2][8], rsel[2][8], rdone[2][8];
    int rpts[8][4];
    int rdat[8][4];

    task automatic model_clear();
        for (int id = 0; id < 2; id++) begin
            m_iss[id] = 0; m_drain[id] = 0; m_k[id] = 0; m_s[id] = 0; m_hc[id] = 0;
            for (int s = 0; s < 8; s++) begin rv[id][s] = 0; rsel[id][s] = 0; rdone[id][s] = 0; end
        end
    endtask

    task automatic model_step(input int id);
        int  slot, ns, g;
        bit  idle;
        slot = cyc % 8;
        g    = 1 << (nlog_of(id) - 2);
        idle = (m_iss[id] == 0) && (m_drain[id] == 0);
        if (m_drain[id] != 0 && rdone[id][slot] != 0) m_drain[id] = 0;
        rv[id][slot] = 0; rsel[id][slot] = 0; rdone[id][slot] = 0;
        if (m_iss[id] != 0) begin
            if (HOLD) begin
                if (m_hc[id] < 65535) m_hc[id]++;
            end else begin
                ns = (cyc + lat_of(id)) % 8;
                rv[id][ns]    = 1;
                rsel[id][ns]  = dsum(gbase(m_s[id], m_k[id]));
                rdone[id][ns] = (m_k[id] == g - 1) ? 1 : 0;
                if (id == 0) for (int j = 0; j < 4; j++) rpts[ns][j] = gpt(m_s[id], m_k[id], j);
                m_k[id]++;
                if (m_k[id] == g) begin m_iss[id] = 0; m_drain[id] = 1; end
            end
        end
        if (idle && START && (int'(STAGE) < nlog_of(id) / 2)) begin
            m_iss[id] = 1; m_k[id] = 0; m_s[id] = int'(STAGE); m_hc[id] = 0;
        end
    endtask

    task automatic check_dut(input int id, input int re, input int a0, input int a1, input int a2,
                             input int a3, input int v, input int sl, input int dn, input int by);
        string p;
        int    slot, ere;
        int    act[4];
        p    = (id == 0) ? "A" : "B";
        slot = cyc % 8;
        ere  = (m_iss[id] != 0 && HOLD == 1'b0) ? 1 : 0;
        act  = '{a0, a1, a2, a3};
        chk($sformatf("%s.rd_en", p), re, ere);
        for (int b = 0; b < 4; b++)
            chk($sformatf("%s.rd_addr%0d", p, b), act[b], (ere != 0) ? gaddr(m_s[id], m_k[id], b) : 0);
        chk($sformatf("%s.valid_out", p), v, rv[id][slot]);
        chk($sformatf("%s.sel_out", p), sl, rsel[id][slot]);
        chk($sformatf("%s.done", p), dn, rdone[id][slot]);
        chk($sformatf("%s.busy", p), by, (m_iss[id] != 0 || m_drain[id] != 0) ? 1 : 0);
    endtask

    always @(posedge CLK) begin
        if (!RSTn) model_clear();
        else begin model_step(0); model_step(1); end
        cyc++;
    end

    always @(negedge CLK) begin : neg_chk
        int bank, q;
        if (!RSTn) model_clear();
        check_dut(0, int'(a_rd_en), int'(a_addr0), int'(a_addr1), int'(a_addr2), int'(a_addr3),
                  int'(a_vld), int'(a_sel), int'(a_done), int'(a_busy));
        check_dut(1, int'(b_rd_en), int'(b_addr0), int'(b_addr1), int'(b_addr2), int'(b_addr3),
                  int'(b_vld), int'(b_sel), int'(b_done), int'(b_busy));
`ifdef PERM_RD_AGU_HOLD_CNT_EN
        chk("A.hold_cnt", int'(a_hc), m_hc[0]);
        chk("B.hold_cnt", int'(b_hc), m_hc[1]);
`endif
        // bank data through the rotation permuter must come out in natural point order
        if (rv[0][cyc % 8] != 0) begin
            for (int j = 0; j < 4; j++) begin
                bank = (j + int'(a_sel)) % 4;
                q    = inv(bank, rdat[cyc % 8][bank]);
                chk($sformatf("A.perm_q%0d", j), q, rpts[cyc % 8][j]);
            end
        end
        if (a_rd_en) rdat[(cyc + 1) % 8] = '{int'(a_addr0), int'(a_addr1), int'(a_addr2), int'(a_addr3)};
    end

    // ---------------- directed stimulus
    typedef struct {
        int st, stg, hd, re, a0, a1, a2, a3, v, sl, dn, by;
    } vec_t;
    vec_t tbl [14];

    task automatic drive(input int st, input int stg, input int hd);
        @(posedge CLK); #1;
        START = (st != 0);
        STAGE = 4'(stg);
        HOLD  = (hd != 0);
        @(negedge CLK);
    endtask

    initial begin
        int nre, nv, nd, nb, doff;
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 1, 2, 2, 2, 2, 1, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 1, 3, 3, 3, 3, 1, 2, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 1, 2, 3, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 3, 0, 1, 2, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 1, 2, 3, 0, 1, 1, 1, 0, 1};
        tbl[11] = '{0, 0, 0, 1, 1, 2, 3, 0, 1, 2, 0, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        RSTn = 1'b0; START = 1'b0; HOLD = 1'b0; STAGE = 4'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset.rd_en", int'(a_rd_en), 0);
        chk("reset.rd_addr1", int'(a_addr1), 0);
        chk("reset.valid_out", int'(a_vld), 0);
        chk("reset.sel_out", int'(a_sel), 0);
        chk("reset.busy", int'(a_busy), 0);
        chk("reset.done", int'(a_done), 0);
        @(posedge CLK); #1; RSTn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].st, tbl[i].stg, tbl[i].hd);
            chk($sformatf("tbl%0d.rd_en", i), int'(a_rd_en), tbl[i].re);
            chk($sformatf("tbl%0d.rd_addr0", i), int'(a_addr0), tbl[i].a0);
            chk($sformatf("tbl%0d.rd_addr1", i), int'(a_addr1), tbl[i].a1);
            chk($sformatf("tbl%0d.rd_addr2", i), int'(a_addr2), tbl[i].a2);
            chk($sformatf("tbl%0d.rd_addr3", i), int'(a_addr3), tbl[i].a3);
            chk($sformatf("tbl%0d.valid_out", i), int'(a_vld), tbl[i].v);
            chk($sformatf("tbl%0d.sel_out", i), int'(a_sel), tbl[i].sl);
            chk($sformatf("tbl%0d.done", i), int'(a_done), tbl[i].dn);
            chk($sformatf("tbl%0d.busy", i), int'(a_busy), tbl[i].by);
        end

        // HOLD for two cycles after group 1, with a START arriving while busy
        nre = 0; nv = 0; doff = -1;
        for (int c = 0; c < 10; c++) begin
            drive((c == 0 || c == 3) ? 1 : 0, (c == 3) ? 0 : 1, (c == 3 || c == 4) ? 1 : 0);
            nre += int'(a_rd_en);
            nv  += int'(a_vld);
            if (a_done) doff = c;
`ifdef PERM_RD_AGU_HOLD_CNT_EN
            if (c == 8) chk("hold.hold_cnt", int'(a_hc), 2);
`endif
        end
        chk("hold.rd_en_count", nre, 4);
        chk("hold.valid_count", nv, 4);
        chk("hold.done_offset", doff, 7);

        // illegal stage while idle
        nre = 0; nb = 0;
        for (int c = 0; c < 4; c++) begin
            drive((c == 0) ? 1 : 0, 2, 0);
            nre += int'(a_rd_en);
            nb  += int'(a_busy);
        end
        chk("illegal_stage.rd_en_count", nre, 0);
        chk("illegal_stage.busy_count", nb, 0);

        // reset after group 1 issues
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        @(posedge CLK); #1;
        RSTn = 1'b0; START = 1'b0;
        #1;
        chk("rstmid.rd_en", int'(a_rd_en), 0);
        chk("rstmid.rd_addr0", int'(a_addr0), 0);
        chk("rstmid.valid_out", int'(a_vld), 0);
        chk("rstmid.sel_out", int'(a_sel), 0);
        chk("rstmid.busy", int'(a_busy), 0);
        chk("rstmid.done", int'(a_done), 0);
        @(negedge CLK);
        @(posedge CLK); #1; RSTn = 1'b1;
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0);
            nv += int'(a_vld);
        end
        chk("rstmid.stale_valid", nv, 0);
        nre = 0; nv = 0; nd = 0;
        for (int c = 0; c < 7; c++) begin
            drive((c == 0) ? 1 : 0, 0, 0);
            nre += int'(a_rd_en);
            nv  += int'(a_vld);
            nd  += int'(a_done);
        end
        chk("rstmid.fresh_rd_en_count", nre, 4);
        chk("rstmid.fresh_valid_count", nv, 4);
        chk("rstmid.fresh_done_count", nd, 1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            RSTn  = ($urandom_range(0, 499) != 0);
            START = ($urandom_range(0, 5) == 0);
            STAGE = 4'($urandom_range(0, 3));
            HOLD  = ($urandom_range(0, 3) == 0);
        end
        @(posedge CLK); #1;
        RSTn = 1'b1; START = 1'b0; HOLD = 1'b0;
        repeat (30) @(posedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perm_rd_agu.md
Name: perm_rd_agu

Overview:
- Read-side address generator and sequencer for the 4-bank conflict-free radix-4 FFT memory.
- For each butterfly group of a stage it issues one read to all 4 banks with per-bank addresses.
- It also produces the 2-bit rotation select and valid, delayed to line up with bank read data.
- Sits directly upstream of the 4-lane rotation permuter: SEL_OUT drives its SEL, and bank outputs drive D0..D3. Permuter outputs Q0..Q3 are then butterfly inputs x0..x3 in natural order.

Parameters:
- N_LOG2, 10, log2 of FFT points. Must be even and >= 4.
- RD_LAT, 1, bank read latency in cycles from RD_EN to data. Must be >= 1.
- ADDR_W, N_LOG2-2, per-bank address width (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge
- RSTn  in  1  reset, asynchronous, active-low
- START  in  1  single-cycle pulse; begins one stage pass
- STAGE  in  4  radix-4 stage index s, sampled with START
- HOLD  in  1  freezes group issue while high
- RD_EN  out  1  bank read strobe, common to all 4 banks
- RD_ADDR0..RD_ADDR3  out  ADDR_W each  read address for banks 0..3
- SEL_OUT  out  2  rotation select, aligned to bank data
- VALID_OUT  out  1  bank data and SEL_OUT valid this cycle
- BUSY  out  1  pass in progress
- DONE  out  1  one-cycle pulse on the last VALID_OUT of a pass

Behaviour:
- Reset: RD_EN=0, RD_ADDR*=0, SEL_OUT=0, VALID_OUT=0, BUSY=0, DONE=0. Group counter and delay line are cleared. Reset mid-pass aborts the pass, and no stale VALID_OUT emerges afterwards.
- Memory map, for point index i:
  - bank b(i) = (sum of base-4 digits of i) mod 4
  - bank address a(i) = i >> 2
- Group generation, for group k in 0..N/4-1 at stage s:
  - base(k) = ((k >> 2s) << (2s+2)) | (k & (4^s - 1))
  - points p_j = base(k) + j*4^s for j = 0..3
  - b0 = b(base(k)); point p_j lives in bank (b0+j) mod 4
- Per issued group:
  - RD_ADDR[(b0+j) mod 4] = a(p_j) for each j
  - the rotation value carried into the delay line = b0
- FSM states:
  - IDLE: START with STAGE < N_LOG2/2 → RUN, k=0, stage latched. START with an illegal STAGE is ignored (stays IDLE).
  - RUN: each cycle with HOLD=0 issues group k (RD_EN=1, addresses registered) and increments k. With HOLD=1, RD_EN=0 and k is held. After issuing k = N/4-1 → DRAIN.
  - DRAIN: wait for the delay line to empty, then → IDLE.
- Timing:
  - START sampled high at cycle T; group 0 issues at T+1.
  - Without HOLD, group k issues at T+1+k.
  - Delay line, RD_LAT deep, carries {valid, b0}. VALID_OUT/SEL_OUT for a group appear exactly RD_LAT cycles after its RD_EN, and keep flowing during HOLD.
- DONE asserts in the same cycle as the VALID_OUT of group N/4-1.
- BUSY is high from T+1 through the DONE cycle inclusive, and low in IDLE.
- START while BUSY is ignored. A new START is accepted in the cycle after DONE.
- HOLD asserted in IDLE or DRAIN has no effect.
- Arithmetic: the digit sum is computed mod 4 with 2-bit wrap. Every address is < 2^ADDR_W, and the counter does not wrap within a pass.

Optional Feature:
- Macro PERM_RD_AGU_HOLD_CNT_EN.
- When defined, adds output HOLD_CNT[15:0]:
  - counts cycles in RUN with HOLD=1
  - cleared on reset and on each accepted START
  - saturates at 16'hFFFF
- When undefined, the port and counter are absent, and all other behaviour is identical.

Test Plan (N_LOG2=4, RD_LAT=1 unless noted):
- Stage 0 pass: START, STAGE=0 at T → RD_EN at T+1..T+4.
  - addresses: all 0, all 1, all 2, all 3
  - SEL_OUT at T+2..T+5: 0, 1, 2, 3
  - DONE at T+5, BUSY low at T+6
- Stage 1 pass:
  - group 0: RD_ADDR0..3 = 0,1,2,3, SEL_OUT=0
  - group 1: RD_ADDR0..3 = 3,0,1,2, SEL_OUT=1
  - bank contents holding i at a(i), fed through the permuter, yield Q0..Q3 = 1,5,9,13
- HOLD high for 2 cycles after group 1 issues → groups 2 and 3 issue 2 cycles later. Total VALID_OUT count is 4, DONE is delayed 2 cycles, and HOLD_CNT=2 with the macro defined.
- START again while BUSY, and START with STAGE=2 while IDLE → both ignored: no RD_EN, BUSY stays as before.
- RD_LAT=3: every VALID_OUT lags its RD_EN by exactly 3 cycles, and DONE coincides with the 4th VALID_OUT.
- RSTn low after group 1 issues → all outputs 0 immediately. No VALID_OUT after release, and a fresh START runs a normal pass.
